// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch front end owning the PC and issuing word fetches over req/ack
// Ports: CLK/Reset clock and async active-high reset; ImemReq/ImemAddr/ImemAck/ImemData memory handshake;
// Instruction/InstrValid to decode; CurrentPC fetched or held address; NextPC/Advance PC reload from next-PC
// logic; Fault sticky misalignment or timeout flag; FetchCount completed fetch count.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [63:0] CurrentPC,
    input  logic [63:0] NextPC,
    input  logic        Advance,
    output logic        Fault,
    output logic [31:0] FetchCount
);
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_VALID, S_FAULT} state_t;
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        w_last;
    assign w_last   = r_cnt == 16'(TIMEOUT - 1);
    assign ImemAddr = CurrentPC;
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) r_state <= S_BOOT;
        else       r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:  w_next = CurrentPC[1:0] != 2'b00 ? S_FAULT : S_FETCH;
            S_FETCH: w_next = ImemAck ? S_VALID : w_last ? S_FAULT : S_FETCH;
            S_VALID: w_next = !Advance ? S_VALID : NextPC[1:0] != 2'b00 ? S_FAULT : S_FETCH;
            S_FAULT: w_next = S_FAULT;
        endcase
    end
    always_comb begin
        ImemReq    = r_state == S_FETCH;
        InstrValid = r_state == S_VALID;
        Fault      = r_state == S_FAULT;
    end
    // The wait counter only matters in S_FETCH; it is cleared on every ack so each fetch gets a full budget.
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            CurrentPC   <= RESET_PC;
            Instruction <= 32'h0;
            FetchCount  <= 32'h0;
            r_cnt       <= 16'h0;
        end else begin
            if (r_state == S_FETCH) begin
                if (ImemAck) begin
                    Instruction <= ImemData;
                    FetchCount  <= FetchCount + 32'h1;
                    r_cnt       <= 16'h0;
                end else r_cnt <= r_cnt + 16'h1;
            end
            if (r_state == S_VALID && Advance) CurrentPC <= NextPC;
        end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = 32'h0;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [63:0] CurrentPC;
    logic [63:0] NextPC = 64'h0;
    logic        Advance = 1'b0;
    logic        Fault;
    logic [31:0] FetchCount;
    logic        b_Reset = 1'b1;
    logic        b_ImemReq;
    logic [63:0] b_ImemAddr;
    logic [31:0] b_Instruction;
    logic        b_InstrValid;
    logic [63:0] b_CurrentPC;
    logic        b_Fault;
    logic [31:0] b_FetchCount;
    int          n_chk = 0;
    int          n_fail = 0;
    always #5 CLK = ~CLK;
    instr_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(8)) dut (
        .CLK(CLK), .Reset(Reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
        .ImemData(ImemData), .Instruction(Instruction), .InstrValid(InstrValid), .CurrentPC(CurrentPC),
        .NextPC(NextPC), .Advance(Advance), .Fault(Fault), .FetchCount(FetchCount)
    );
    instr_fetch_unit #(.RESET_PC(64'h2), .TIMEOUT(8)) dut_b (
        .CLK(CLK), .Reset(b_Reset), .ImemReq(b_ImemReq), .ImemAddr(b_ImemAddr), .ImemAck(1'b0),
        .ImemData(32'h0), .Instruction(b_Instruction), .InstrValid(b_InstrValid), .CurrentPC(b_CurrentPC),
        .NextPC(64'h0), .Advance(1'b0), .Fault(b_Fault), .FetchCount(b_FetchCount)
    );
    task automatic step;
        @(posedge CLK);
        #1;
    endtask
    task automatic test_reset;
        Reset = 1'b1;
        step;
        step;
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", ImemReq); end
        n_chk++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", InstrValid); end
        n_chk++; if (Fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b exp 0", Fault); end
        n_chk++; if (FetchCount !== 32'h0) begin n_fail++; $display("FAIL rst_count got %h exp 0", FetchCount); end
        n_chk++; if (CurrentPC !== 64'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", CurrentPC); end
        n_chk++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", Instruction); end
    endtask
    task automatic test_first_fetch;
        Reset = 1'b0;
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL boot_req got %b exp 0", ImemReq); end
        step;
        n_chk++; if (ImemReq !== 1'b1) begin n_fail++; $display("FAIL ff_req got %b exp 1", ImemReq); end
        n_chk++; if (ImemAddr !== 64'h0) begin n_fail++; $display("FAIL ff_addr got %h exp 0", ImemAddr); end
        ImemAck = 1'b1;
        ImemData = 32'h8B020020;
        step;
        ImemAck = 1'b0;
        n_chk++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL ff_valid got %b exp 1", InstrValid); end
        n_chk++; if (Instruction !== 32'h8B020020) begin n_fail++; $display("FAIL ff_instr got %h exp 8b020020", Instruction); end
        n_chk++; if (FetchCount !== 32'h1) begin n_fail++; $display("FAIL ff_count got %h exp 1", FetchCount); end
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL ff_req_lo got %b exp 0", ImemReq); end
    endtask
    task automatic test_advance;
        Advance = 1'b1;
        NextPC = 64'h4;
        step;
        Advance = 1'b0;
        n_chk++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL adv_valid got %b exp 0", InstrValid); end
        n_chk++; if (ImemReq !== 1'b1) begin n_fail++; $display("FAIL adv_req got %b exp 1", ImemReq); end
        n_chk++; if (ImemAddr !== 64'h4) begin n_fail++; $display("FAIL adv_addr got %h exp 4", ImemAddr); end
        ImemAck = 1'b1;
        ImemData = 32'h91000421;
        step;
        ImemAck = 1'b0;
        n_chk++; if (Instruction !== 32'h91000421) begin n_fail++; $display("FAIL adv_instr got %h exp 91000421", Instruction); end
        Advance = 1'b1;
        NextPC = 64'h100;
        step;
        Advance = 1'b0;
        n_chk++; if (ImemAddr !== 64'h100) begin n_fail++; $display("FAIL br_addr got %h exp 100", ImemAddr); end
        ImemAck = 1'b1;
        ImemData = 32'hD503201F;
        step;
        ImemAck = 1'b0;
        n_chk++; if (FetchCount !== 32'h3) begin n_fail++; $display("FAIL br_count got %h exp 3", FetchCount); end
        n_chk++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL br_valid got %b exp 1", InstrValid); end
    endtask
    task automatic test_wait_states;
        Advance = 1'b1;
        NextPC = 64'h104;
        step;
        Advance = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ImemReq !== 1'b1) begin n_fail++; $display("FAIL ws_req[%0d] got %b exp 1", i, ImemReq); end
            n_chk++; if (ImemAddr !== 64'h104) begin n_fail++; $display("FAIL ws_addr[%0d] got %h exp 104", i, ImemAddr); end
            n_chk++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL ws_valid[%0d] got %b exp 0", i, InstrValid); end
            n_chk++; if (FetchCount !== 32'h3) begin n_fail++; $display("FAIL ws_count[%0d] got %h exp 3", i, FetchCount); end
            ImemData = 32'hF8400000 + 32'(i);
            if (i == 3) ImemAck = 1'b1;
            step;
        end
        ImemAck = 1'b0;
        n_chk++; if (Instruction !== 32'hF8400003) begin n_fail++; $display("FAIL ws_instr got %h exp f8400003", Instruction); end
        n_chk++; if (FetchCount !== 32'h4) begin n_fail++; $display("FAIL ws_count got %h exp 4", FetchCount); end
        ImemAck = 1'b1;
        ImemData = 32'hDEADBEEF;
        step;
        ImemAck = 1'b0;
        n_chk++; if (Instruction !== 32'hF8400003) begin n_fail++; $display("FAIL spur_instr got %h exp f8400003", Instruction); end
        n_chk++; if (FetchCount !== 32'h4) begin n_fail++; $display("FAIL spur_count got %h exp 4", FetchCount); end
        n_chk++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL spur_valid got %b exp 1", InstrValid); end
    endtask
    task automatic test_timeout;
        int n = 0;
        Advance = 1'b1;
        NextPC = 64'h200;
        step;
        Advance = 1'b0;
        for (int i = 0; i < 20 && ImemReq; i++) begin
            n++;
            step;
        end
        n_chk++; if (n !== 8) begin n_fail++; $display("FAIL to_cycles got %0d exp 8", n); end
        n_chk++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL to_fault got %b exp 1", Fault); end
        Advance = 1'b1;
        ImemAck = 1'b1;
        NextPC = 64'h0;
        step;
        step;
        Advance = 1'b0;
        ImemAck = 1'b0;
        n_chk++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", Fault); end
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL to_req got %b exp 0", ImemReq); end
        n_chk++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL to_valid got %b exp 0", InstrValid); end
        n_chk++; if (CurrentPC !== 64'h200) begin n_fail++; $display("FAIL to_pc got %h exp 200", CurrentPC); end
        n_chk++; if (FetchCount !== 32'h4) begin n_fail++; $display("FAIL to_count got %h exp 4", FetchCount); end
    endtask
    task automatic test_misalign;
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        step;
        ImemAck = 1'b1;
        ImemData = 32'h8B020020;
        step;
        ImemAck = 1'b0;
        Advance = 1'b1;
        NextPC = 64'h102;
        step;
        Advance = 1'b0;
        n_chk++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault got %b exp 1", Fault); end
        n_chk++; if (CurrentPC !== 64'h102) begin n_fail++; $display("FAIL mis_pc got %h exp 102", CurrentPC); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL mis_req[%0d] got %b exp 0", i, ImemReq); end
            step;
        end
        b_Reset = 1'b0;
        n_chk++; if (b_Fault !== 1'b0) begin n_fail++; $display("FAIL b_boot_fault got %b exp 0", b_Fault); end
        n_chk++; if (b_CurrentPC !== 64'h2) begin n_fail++; $display("FAIL b_pc got %h exp 2", b_CurrentPC); end
        step;
        n_chk++; if (b_Fault !== 1'b1) begin n_fail++; $display("FAIL b_fault got %b exp 1", b_Fault); end
        n_chk++; if (b_ImemReq !== 1'b0) begin n_fail++; $display("FAIL b_req got %b exp 0", b_ImemReq); end
    endtask
    task automatic test_async_reset;
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        step;
        ImemAck = 1'b1;
        step;
        ImemAck = 1'b0;
        Advance = 1'b1;
        NextPC = 64'h8;
        step;
        Advance = 1'b0;
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h8) begin n_fail++; $display("FAIL ar_pre req %b addr %h exp 1 8", ImemReq, ImemAddr); end
        #3;
        Reset = 1'b1;
        #1;
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL ar_req got %b exp 0", ImemReq); end
        n_chk++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", InstrValid); end
        n_chk++; if (FetchCount !== 32'h0) begin n_fail++; $display("FAIL ar_count got %h exp 0", FetchCount); end
        n_chk++; if (CurrentPC !== 64'h0) begin n_fail++; $display("FAIL ar_pc got %h exp 0", CurrentPC); end
        step;
        Reset = 1'b0;
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL ar_boot got %b exp 0", ImemReq); end
        step;
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h0) begin n_fail++; $display("FAIL ar_resume req %b addr %h exp 1 0", ImemReq, ImemAddr); end
    endtask
    initial begin
        test_reset;
        test_first_fetch;
        test_advance;
        test_wait_states;
        test_timeout;
        test_misalign;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
